// File: rtl/br_predictor_btb_pkg.sv
// Shared types for the direct-mapped branch target buffer: 2-bit counter
// encoding, the resettable per-entry state, and perf-counter helpers.
package br_predictor_btb_pkg;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_cnt_t;

  // Resettable half of a BTB entry; tag and target sit in unreset flop arrays.
  typedef struct packed {
    logic    valid;
    bp_cnt_t cnt;
  } bp_entry_t;

  localparam int unsigned BP_PERF_W = 32;

  function automatic logic [BP_PERF_W-1:0] perf_sat_inc(input logic [BP_PERF_W-1:0] v);
    return (&v) ? v : v + BP_PERF_W'(1);
  endfunction

endpackage

// File: rtl/br_predictor_btb_sat_counter2.sv
// Combinational next-state for a 2-bit saturating taken/not-taken counter.
module sat_counter2
  import br_predictor_btb_pkg::*;
(
  input  bp_cnt_t i_cnt,
  input  logic    i_taken,
  output bp_cnt_t o_cnt_c
);

  always_comb begin
    o_cnt_c = i_cnt;
    unique case (i_cnt)
      BP_SNT:  o_cnt_c = i_taken ? BP_WNT : BP_SNT;
      BP_WNT:  o_cnt_c = i_taken ? BP_WT  : BP_SNT;
      BP_WT:   o_cnt_c = i_taken ? BP_ST  : BP_WNT;
      BP_ST:   o_cnt_c = i_taken ? BP_ST  : BP_WT;
      default: o_cnt_c = i_cnt;
    endcase
  end

endmodule

// File: rtl/br_predictor_btb.sv
// Direct-mapped BTB with 2-bit counters: combinational IF-stage lookup,
// ID-stage resolution updates, and saturating branch/mispredict counters.
module br_predictor_btb
  import br_predictor_btb_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned width   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [width-1:0]     BP_lookup_pc_i,
  output logic                 BP_pred_hit_o,
  output logic                 BP_pred_taken_o,
  output logic [width-1:0]     BP_pred_target_o,
  input  logic                 BP_upd_valid_i,
  input  logic [width-1:0]     BP_upd_pc_i,
  input  logic                 BP_upd_taken_i,
  input  logic [width-1:0]     BP_upd_target_i,
  input  logic                 BP_upd_jump_i,
  input  logic                 BP_upd_mispred_i,
  output logic [BP_PERF_W-1:0] BP_branch_cnt_o,
  output logic [BP_PERF_W-1:0] BP_mispred_cnt_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = width - IDX_W - 2;

  bp_entry_t              r_meta [ENTRIES];
  logic [TAG_W-1:0]       r_tag  [ENTRIES];
  logic [width-1:0]       r_tgt  [ENTRIES];
  logic [BP_PERF_W-1:0]   r_branch_cnt;
  logic [BP_PERF_W-1:0]   r_mispred_cnt;

  logic [IDX_W-1:0]       w_lk_idx;
  logic [TAG_W-1:0]       w_lk_tag;
  logic                   w_lk_hit;
  logic                   w_lk_taken;

  logic [IDX_W-1:0]       w_up_idx;
  logic [TAG_W-1:0]       w_up_tag;
  logic                   w_up_hit;
  bp_cnt_t                w_up_cnt;
  bp_cnt_t                w_sat_cnt;
  bp_entry_t              w_meta_nxt;
  logic                   w_meta_we;
  logic                   w_tag_we;
  logic                   w_tgt_we;
  logic                   w_unused;

  assign w_unused = ^BP_upd_pc_i[1:0];

  // Lookup path: reads current table contents only, so a same-cycle update is not visible.
  assign w_lk_idx   = BP_lookup_pc_i[IDX_W+1:2];
  assign w_lk_tag   = BP_lookup_pc_i[width-1:IDX_W+2];
  assign w_lk_hit   = r_meta[w_lk_idx].valid && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_lk_taken = w_lk_hit && r_meta[w_lk_idx].cnt[1];

  assign BP_pred_hit_o    = w_lk_hit;
  assign BP_pred_taken_o  = w_lk_taken;
  assign BP_pred_target_o = w_lk_taken ? r_tgt[w_lk_idx] : BP_lookup_pc_i + width'(4);

  assign w_up_idx = BP_upd_pc_i[IDX_W+1:2];
  assign w_up_tag = BP_upd_pc_i[width-1:IDX_W+2];
  assign w_up_hit = r_meta[w_up_idx].valid && (r_tag[w_up_idx] == w_up_tag);
  assign w_up_cnt = r_meta[w_up_idx].cnt;

  sat_counter2 u_sat_counter2 (
    .i_cnt   (w_up_cnt),
    .i_taken (BP_upd_taken_i),
    .o_cnt_c (w_sat_cnt)
  );

  // Update decode: hits train the counter, taken misses (re)allocate the entry.
  always_comb begin
    w_meta_we        = 1'b0;
    w_tag_we         = 1'b0;
    w_tgt_we         = 1'b0;
    w_meta_nxt.valid = 1'b1;
    w_meta_nxt.cnt   = w_up_cnt;
    if (BP_upd_valid_i) begin
      if (w_up_hit) begin
        w_meta_we      = 1'b1;
        w_tgt_we       = BP_upd_jump_i || BP_upd_taken_i;
        w_meta_nxt.cnt = BP_upd_jump_i ? BP_ST : w_sat_cnt;
      end else if (BP_upd_taken_i) begin
        w_meta_we      = 1'b1;
        w_tag_we       = 1'b1;
        w_tgt_we       = 1'b1;
        w_meta_nxt.cnt = BP_upd_jump_i ? BP_ST : BP_WT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_meta[i] <= '{valid: 1'b0, cnt: BP_WNT};
      end
    end else if (w_meta_we) begin
      r_meta[w_up_idx] <= w_meta_nxt;
    end
  end

  // Tag/target carry no reset; the rst gate keeps writes presented during reset from landing.
  always_ff @(posedge clk) begin
    if (rst && w_tag_we) begin
      r_tag[w_up_idx] <= w_up_tag;
    end
    if (rst && w_tgt_we) begin
      r_tgt[w_up_idx] <= BP_upd_target_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (BP_upd_valid_i) begin
      r_branch_cnt <= perf_sat_inc(r_branch_cnt);
      if (BP_upd_mispred_i) begin
        r_mispred_cnt <= perf_sat_inc(r_mispred_cnt);
      end
    end
  end

  assign BP_branch_cnt_o  = r_branch_cnt;
  assign BP_mispred_cnt_o = r_mispred_cnt;

endmodule

// File: tb/tb_br_predictor_btb.sv
// Self-checking bench for br_predictor_btb: a behavioural BTB model pushes the
// expected lookup/perf-counter view each cycle, popped and compared mid-cycle.
module tb_br_predictor_btb;
  import br_predictor_btb_pkg::*;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned W       = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  BP_lookup_pc_i;
  logic          BP_pred_hit_o;
  logic          BP_pred_taken_o;
  logic [W-1:0]  BP_pred_target_o;
  logic          BP_upd_valid_i;
  logic [W-1:0]  BP_upd_pc_i;
  logic          BP_upd_taken_i;
  logic [W-1:0]  BP_upd_target_i;
  logic          BP_upd_jump_i;
  logic          BP_upd_mispred_i;
  logic [31:0]   BP_branch_cnt_o;
  logic [31:0]   BP_mispred_cnt_o;

  always #5 clk = ~clk;

  br_predictor_btb #(.ENTRIES(ENTRIES), .width(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .BP_lookup_pc_i   (BP_lookup_pc_i),
    .BP_pred_hit_o    (BP_pred_hit_o),
    .BP_pred_taken_o  (BP_pred_taken_o),
    .BP_pred_target_o (BP_pred_target_o),
    .BP_upd_valid_i   (BP_upd_valid_i),
    .BP_upd_pc_i      (BP_upd_pc_i),
    .BP_upd_taken_i   (BP_upd_taken_i),
    .BP_upd_target_i  (BP_upd_target_i),
    .BP_upd_jump_i    (BP_upd_jump_i),
    .BP_upd_mispred_i (BP_upd_mispred_i),
    .BP_branch_cnt_o  (BP_branch_cnt_o),
    .BP_mispred_cnt_o (BP_mispred_cnt_o)
  );

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic [31:0] brc;
    logic [31:0] mpc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model, fixed at 16 entries: index pc[5:2], tag pc[31:6].
  logic        m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  logic [1:0]  m_cnt   [16];
  logic [31:0] m_brc;
  logic [31:0] m_mpc;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 2'b01;
    end
    m_brc = '0;
    m_mpc = '0;
  endtask

  function automatic exp_t model_lookup(input logic [31:0] pc);
    exp_t        e;
    int unsigned i;
    i        = 32'(pc[5:2]);
    e.hit    = m_valid[i] && (m_tag[i] == pc[31:6]);
    e.taken  = e.hit && m_cnt[i][1];
    e.target = e.taken ? m_tgt[i] : pc + 32'd4;
    e.brc    = m_brc;
    e.mpc    = m_mpc;
    return e;
  endfunction

  task automatic model_update(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                              input logic j, input logic mp);
    int unsigned i;
    logic        h;
    i = 32'(pc[5:2]);
    h = m_valid[i] && (m_tag[i] == pc[31:6]);
    if (h) begin
      if (j) begin
        m_cnt[i] = 2'b11;
        m_tgt[i] = tgt;
      end else if (t) begin
        if (m_cnt[i] != 2'b11) m_cnt[i] = m_cnt[i] + 2'd1;
        m_tgt[i] = tgt;
      end else if (m_cnt[i] != 2'b00) begin
        m_cnt[i] = m_cnt[i] - 2'd1;
      end
    end else if (t) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = pc[31:6];
      m_tgt[i]   = tgt;
      m_cnt[i]   = j ? 2'b11 : 2'b10;
    end
    if (m_brc != 32'hFFFF_FFFF) m_brc = m_brc + 32'd1;
    if (mp && (m_mpc != 32'hFFFF_FFFF)) m_mpc = m_mpc + 32'd1;
  endtask

  task automatic drive(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic uj, input logic um);
    BP_lookup_pc_i   = lpc;
    BP_upd_valid_i   = uv;
    BP_upd_pc_i      = upc;
    BP_upd_taken_i   = ut;
    BP_upd_target_i  = utgt;
    BP_upd_jump_i    = uj;
    BP_upd_mispred_i = um;
    exp_q.push_back(model_lookup(lpc));
  endtask

  // Advance one clock; the model takes the update only if the DUT could.
  task automatic cycle();
    @(posedge clk);
    if (BP_upd_valid_i && rst)
      model_update(BP_upd_pc_i, BP_upd_taken_i, BP_upd_target_i, BP_upd_jump_i, BP_upd_mispred_i);
    @(negedge clk);
    BP_upd_valid_i   = 1'b0;
    BP_upd_mispred_i = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      drive(32'h60, (k == 0), 32'h60, 1'b1, 32'h100, 1'b0, 1'b0);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({BP_pred_hit_o, BP_pred_taken_o, BP_pred_target_o, BP_branch_cnt_o, BP_mispred_cnt_o} !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got hit=%b taken=%b tgt=%h br=%0d mp=%0d, want hit=%b taken=%b tgt=%h br=%0d mp=%0d",
                 k, BP_pred_hit_o, BP_pred_taken_o, BP_pred_target_o, BP_branch_cnt_o, BP_mispred_cnt_o,
                 e.hit, e.taken, e.target, e.brc, e.mpc);
      end
      if (k == 0) cycle();
    end
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_allocate();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      drive(32'h40, (k == 0), 32'h40, 1'b1, 32'h80, 1'b0, 1'b0);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({BP_pred_hit_o, BP_pred_taken_o, BP_pred_target_o, BP_branch_cnt_o, BP_mispred_cnt_o} !== e) begin
        errors++;
        $display("FAIL allocate[%0d]: got hit=%b taken=%b tgt=%h br=%0d mp=%0d, want hit=%b taken=%b tgt=%h br=%0d mp=%0d",
                 k, BP_pred_hit_o, BP_pred_taken_o, BP_pred_target_o, BP_branch_cnt_o, BP_mispred_cnt_o,
                 e.hit, e.taken, e.target, e.brc, e.mpc);
      end
      cycle();
    end
  endtask

  task automatic test_hysteresis();
    exp_t e;
    logic tk [6];
    tk = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      drive(32'h40, (k < 5), 32'h40, tk[k], 32'h80, 1'b0, 1'b0);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({BP_pred_hit_o, BP_pred_taken_o, BP_pred_target_o, BP_branch_cnt_o, BP_mispred_cnt_o} !== e) begin
        errors++;
        $display("FAIL hysteresis[%0d]: got hit=%b taken=%b tgt=%h br=%0d mp=%0d, want hit=%b taken=%b tgt=%h br=%0d mp=%0d",
                 k, BP_pred_hit_o, BP_pred_taken_o, BP_pred_target_o, BP_branch_cnt_o, BP_mispred_cnt_o,
                 e.hit, e.taken, e.target, e.brc, e.mpc);
      end
      cycle();
    end
  endtask

  task automatic test_alias();
    exp_t        e;
    logic [31:0] lk [3];
    lk = '{32'h40, 32'h40, 32'h440};
    for (int k = 0; k < 3; k++) begin
      drive(lk[k], (k == 0), 32'h440, 1'b1, 32'h900, 1'b0, 1'b0);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({BP_pred_hit_o, BP_pred_taken_o, BP_pred_target_o, BP_branch_cnt_o, BP_mispred_cnt_o} !== e) begin
        errors++;
        $display("FAIL alias[%0d]: got hit=%b taken=%b tgt=%h br=%0d mp=%0d, want hit=%b taken=%b tgt=%h br=%0d mp=%0d",
                 k, BP_pred_hit_o, BP_pred_taken_o, BP_pred_target_o, BP_branch_cnt_o, BP_mispred_cnt_o,
                 e.hit, e.taken, e.target, e.brc, e.mpc);
      end
      cycle();
    end
  endtask

  task automatic test_same_cycle();
    exp_t        e;
    logic [31:0] lk  [5];
    logic [31:0] up  [5];
    logic        tk  [5];
    logic [31:0] tg  [5];
    logic        jp  [5];
    lk = '{32'h40, 32'h40, 32'h40, 32'h40, 32'h200};
    up = '{32'h40, 32'h40, 32'h40, 32'h200, 32'h0};
    tk = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tg = '{32'h80, 32'hC0, 32'h0, 32'h0, 32'h0};
    jp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      drive(lk[k], (k < 4), up[k], tk[k], tg[k], jp[k], 1'b0);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({BP_pred_hit_o, BP_pred_taken_o, BP_pred_target_o, BP_branch_cnt_o, BP_mispred_cnt_o} !== e) begin
        errors++;
        $display("FAIL same_cycle[%0d]: got hit=%b taken=%b tgt=%h br=%0d mp=%0d, want hit=%b taken=%b tgt=%h br=%0d mp=%0d",
                 k, BP_pred_hit_o, BP_pred_taken_o, BP_pred_target_o, BP_branch_cnt_o, BP_mispred_cnt_o,
                 e.hit, e.taken, e.target, e.brc, e.mpc);
      end
      cycle();
    end
  endtask

  task automatic test_counters();
    exp_t e;
    logic tk [5];
    logic mp [5];
    tk = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    mp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    rst = 1'b0;
    model_reset();
    #2;
    rst = 1'b1;
    // Lookup of 0x100 each step shows the mispredict flag never changes that entry.
    for (int k = 0; k < 9; k++) begin
      if (k < 5) begin
        drive(32'h100, 1'b1, 32'h100 + 32'(k) * 32'h40, tk[k], 32'h300 + 32'(k), 1'b0, mp[k]);
      end else if (k == 5) begin
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      end else if (k == 6) begin
        drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h500, 1'b0, 1'b1);
      end else if (k == 7) begin
        rst = 1'b0;
        model_reset();
        drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h500, 1'b0, 1'b1);
      end else begin
        drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      end
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({BP_pred_hit_o, BP_pred_taken_o, BP_pred_target_o, BP_branch_cnt_o, BP_mispred_cnt_o} !== e) begin
        errors++;
        $display("FAIL counters[%0d]: got hit=%b taken=%b tgt=%h br=%0d mp=%0d, want hit=%b taken=%b tgt=%h br=%0d mp=%0d",
                 k, BP_pred_hit_o, BP_pred_taken_o, BP_pred_target_o, BP_branch_cnt_o, BP_mispred_cnt_o,
                 e.hit, e.taken, e.target, e.brc, e.mpc);
      end
      if (k == 5) begin
        checks++;
        if (BP_branch_cnt_o !== 32'd5 || BP_mispred_cnt_o !== 32'd2) begin
          errors++;
          $display("FAIL perf_counts: got br=%0d mp=%0d, want br=5 mp=2", BP_branch_cnt_o, BP_mispred_cnt_o);
        end
      end
      if (k != 6) cycle();
    end
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [31:0] pool [8];
    logic        uj;
    pool = '{32'h40, 32'h440, 32'h44, 32'h844, 32'h3C, 32'h1000, 32'hFFFF_FFFC, 32'h7C};
    for (int k = 0; k < 200; k++) begin
      uj = ($urandom_range(0, 3) == 0);
      drive(pool[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)],
            uj | 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, uj, 1'($urandom_range(0, 1)));
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({BP_pred_hit_o, BP_pred_taken_o, BP_pred_target_o, BP_branch_cnt_o, BP_mispred_cnt_o} !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got hit=%b taken=%b tgt=%h br=%0d mp=%0d, want hit=%b taken=%b tgt=%h br=%0d mp=%0d",
                 k, BP_pred_hit_o, BP_pred_taken_o, BP_pred_target_o, BP_branch_cnt_o, BP_mispred_cnt_o,
                 e.hit, e.taken, e.target, e.brc, e.mpc);
      end
      cycle();
    end
  endtask

  initial begin
    rst              = 1'b0;
    BP_lookup_pc_i   = '0;
    BP_upd_valid_i   = 1'b0;
    BP_upd_pc_i      = '0;
    BP_upd_taken_i   = 1'b0;
    BP_upd_target_i  = '0;
    BP_upd_jump_i    = 1'b0;
    BP_upd_mispred_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_allocate();
    test_hysteresis();
    test_alias();
    test_same_cycle();
    test_counters();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
